// File: rtl/fport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fport_arbiter
//  Purpose  : Round-robin sharing of one DW-bit output port between NREQ
//             requesters; the winner's pattern is held for HOLD cycles.
//  Option   : FPORT_ARB_EXTEND_EN - sole requester may extend its grant.
//  Revision : 1.0 - initial release
// ============================================================================
module fport_arbiter #(
  parameter int              NREQ     = 4,
  parameter int              DW       = 4,
  parameter int              HOLD     = 8,
  parameter logic [DW-1:0]   IDLE_PAT = '0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] pat,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      data,
  output logic               busy
);

  localparam int c_pw = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_cw = (HOLD > 1) ? $clog2(HOLD + 1) : 1;
  localparam logic [c_cw-1:0] c_reload = c_cw'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t            r_state, w_state_nx;
  logic [NREQ-1:0]   r_gnt, w_gnt_nx;
  logic [NREQ-1:0]   r_done, w_done_nx;
  logic [DW-1:0]     r_data, w_data_nx;
  logic [c_cw-1:0]   r_cnt, w_cnt_nx;
  logic [c_pw-1:0]   r_ptr, w_ptr_nx;
  logic [c_pw-1:0]   r_win, w_win_nx;
  logic [c_pw-1:0]   w_sel;
  logic              w_rel;
  logic [DW-1:0]     w_pat_arr [NREQ];

  genvar g;
  generate
    for (g = 0; g < NREQ; g++) begin : g_pat
      assign w_pat_arr[g] = pat[g*DW +: DW];
    end
  endgenerate

  // Walk from the highest offset down so the nearest set bit above ptr wins.
  always_comb begin
    w_sel = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(r_ptr) + i) % NREQ])
        w_sel = c_pw'((int'(r_ptr) + i) % NREQ);
    end
  end

`ifdef FPORT_ARB_EXTEND_EN
  logic w_others;
  assign w_others = |(req & ~r_gnt);
`endif

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_done_nx  = '0;
    w_data_nx  = r_data;
    w_cnt_nx   = r_cnt;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_rel      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = NREQ'(1) << w_sel;
          w_data_nx  = w_pat_arr[w_sel];
          w_cnt_nx   = c_reload;
          w_win_nx   = w_sel;
        end
      end
      S_GRANT: begin
        if (!req[r_win]) begin
          w_rel = 1'b1;
        end else if (r_cnt == '0) begin
`ifdef FPORT_ARB_EXTEND_EN
          if (!w_others)
            w_cnt_nx = c_reload;
          else
            w_rel = 1'b1;
`else
          w_rel = 1'b1;
`endif
        end else begin
          w_cnt_nx = r_cnt - c_cw'(1);
        end
      end
      S_RELEASE: w_state_nx = S_IDLE;
      default:   w_state_nx = S_IDLE;
    endcase

    if (w_rel) begin
      w_state_nx = S_RELEASE;
      w_gnt_nx   = '0;
      w_data_nx  = IDLE_PAT;
      w_done_nx  = r_gnt;
      w_ptr_nx   = (r_win == c_pw'(NREQ - 1)) ? '0 : r_win + c_pw'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_done  <= '0;
      r_data  <= IDLE_PAT;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_done  <= w_done_nx;
      r_data  <= w_data_nx;
      r_cnt   <= w_cnt_nx;
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign data = r_data;
  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fport_arbiter
//  Purpose  : Directed self-checking bench for fport_arbiter (NREQ=4, DW=4,
//             HOLD=8); honours FPORT_ARB_EXTEND_EN when defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fport_arbiter;

`ifdef FPORT_ARB_EXTEND_EN
  localparam bit c_ext   = 1'b1;
  localparam int c_len   = 16;
  localparam int c_raise = 12;
`else
  localparam bit c_ext   = 1'b0;
  localparam int c_len   = 8;
  localparam int c_raise = 5;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  req;
  logic [15:0] pat;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  fport_arbiter #(
    .NREQ     (4),
    .DW       (4),
    .HOLD     (8),
    .IDLE_PAT (4'b0000)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .req  (req),
    .pat  (pat),
    .gnt  (gnt),
    .done (done),
    .data (data),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    logic [3:0] prev_oh;
    int         idx;

    rstn = 1'b0; req = '0; pat = '0;
    tick; tick;
    chk("rst_data", data, 4'h0);
    chk("rst_gnt",  gnt,  4'h0);
    chk("rst_done", done, 4'h0);
    chk("rst_busy", busy, 1'b0);
    rstn = 1'b1;
    tick;
    chk("idle_busy", busy, 1'b0);

    // single requester, pat[2]=1010, expiry after 8 cycles
    pat = 16'h0A00; req = 4'b0100;
    tick;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick;
      chk("single_gnt",  gnt,  4'b0100);
      chk("single_data", data, 4'hA);
      chk("single_busy", busy, 1'b1);
      if (c_ext && k == 7) req = 4'b0000;
    end
    tick;
    chk("single_done", done, 4'b0100);
    chk("single_rel_data", data, 4'h0);
    chk("single_rel_gnt", gnt, 4'h0);
    chk("single_rel_busy", busy, 1'b1);
    req = 4'b0000;
    tick;
    chk("single_idle_done", done, 4'h0);
    chk("single_idle_busy", busy, 1'b0);

    // wrap: ptr=3, req=1001 -> 3 then 0
    pat = 16'hC005; req = 4'b1001;
    tick;
    chk("wrap_gnt3", gnt, 4'b1000);
    chk("wrap_data3", data, 4'hC);
    repeat (7) tick;
    chk("wrap_data3_end", data, 4'hC);
    tick;
    chk("wrap_done3", done, 4'b1000);
    req = 4'b0001;
    tick;
    chk("wrap_idle_gnt", gnt, 4'h0);
    tick;
    chk("wrap_gnt0", gnt, 4'b0001);
    chk("wrap_data0", data, 4'h5);
    req = 4'b0000;
    tick;
    chk("drop0_done", done, 4'b0001);
    tick;

    // early drop of req[1]; pattern change during grant ignored
    pat = 16'h0060; req = 4'b0010;
    tick;
    chk("drop_gnt", gnt, 4'b0010);
    chk("drop_data", data, 4'h6);
    pat = 16'h00F0;
    tick;
    chk("drop_hold1", data, 4'h6);
    tick;
    chk("drop_hold2", data, 4'h6);
    req = 4'b0000;
    tick;
    chk("drop_done", done, 4'b0010);
    chk("drop_rel_data", data, 4'h0);
    chk("drop_rel_gnt", gnt, 4'h0);
    tick;
    chk("drop_idle_done", done, 4'h0);
    chk("drop_idle_busy", busy, 1'b0);

    // asynchronous reset mid-grant
    pat = 16'h0C00; req = 4'b0100;
    tick; tick;
    chk("mid_gnt", gnt, 4'b0100);
    rstn = 1'b0;
    #1;
    chk("mid_rst_data", data, 4'h0);
    chk("mid_rst_gnt",  gnt,  4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 4'h0);
    req = 4'b0000;
    tick;
    chk("mid_rst_nodone", done, 4'h0);

    // round robin from ptr=0 with all requests held
    rstn = 1'b1; pat = 16'hDCBA; req = 4'b1111;
    tick;
    prev_oh = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      idx = g % 4;
      oh  = 4'b0001 << idx;
      chk("rr_gnt",  gnt,  oh);
      chk("rr_data", data, 4'hA + 4'(idx));
      if (g == 4) break;
      repeat (7) tick;
      chk("rr_data_end", data, 4'hA + 4'(idx));
      tick;
      chk("rr_done", done, oh);
      tick;
      chk("rr_gap_gnt", gnt, 4'h0);
      prev_oh = oh;
      tick;
    end
    chk("rr_last_prev", prev_oh, 4'b1000);
    req = 4'b0000;
    tick;
    chk("rr_final_done", done, 4'b0001);
    tick;

`ifdef FPORT_ARB_EXTEND_EN
    // sole requester keeps extending: 24 continuous data cycles, one done
    pat = 16'h0007; req = 4'b0001;
    tick;
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) tick;
      chk("ext_data", data, 4'h7);
      chk("ext_nodone", done, 4'h0);
    end
    req = 4'b0000;
    tick;
    chk("ext_done", done, 4'b0001);
    tick;
`endif

    // competing request ends grant 0 at the next expiry; grant 2 follows
    pat = 16'h0E07; req = 4'b0001;
    tick;
    for (int k = 1; k <= c_len; k++) begin
      if (k > 1) tick;
      chk("comp_gnt0",  gnt,  4'b0001);
      chk("comp_data0", data, 4'h7);
      if (k == c_raise) req = 4'b0101;
    end
    tick;
    chk("comp_done0", done, 4'b0001);
    chk("comp_rel_gnt", gnt, 4'h0);
    req = 4'b0100;
    tick;
    chk("comp_idle_gnt", gnt, 4'h0);
    tick;
    chk("comp_gnt2",  gnt,  4'b0100);
    chk("comp_data2", data, 4'hE);
    req = 4'b0000;
    tick;
    chk("comp_done2", done, 4'b0100);
    tick;
    chk("comp_end_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
